// File: rtl/alsu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_result_buffer
//  Description : Show-ahead FIFO that captures qualified ALSU results, tags
//                invalid ones, and keeps drop/invalid statistics plus a
//                running sum of valid results drained by the consumer.
//  Revision    : 1.0  initial release
// ============================================================================
module alsu_result_buffer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_out,
    input  logic [15:0]              in_leds,
    input  logic [2:0]               in_opcode,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_opcode,
    output logic                     out_invalid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              drop_count,
    output logic [15:0]              invalid_count,
    output logic [CNT_W-1:0]         acc
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              EW       = DATA_W + 4;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [15:0]     SAT_MAX  = 16'hFFFF;

    // Entry layout: {invalid, opcode[2:0], data[DATA_W-1:0]}
    logic [EW-1:0]      mem_q [DEPTH];

    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [15:0]        drop_q, drop_d;
    logic [15:0]        inv_q, inv_d;
    logic [CNT_W-1:0]   acc_q, acc_d;

    logic               pop_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic               in_invalid;
    logic [EW-1:0]      head;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign count       = count_q;
    assign out_valid   = !empty;
    assign head        = mem_q[rd_ptr_q];
    assign out_data    = head[DATA_W-1:0];
    assign out_opcode  = head[DATA_W+2:DATA_W];
    assign out_invalid = head[EW-1];
    assign drop_count    = drop_q;
    assign invalid_count = inv_q;
    assign acc           = acc_q;

    assign in_invalid = (in_leds != 16'h0000);

    // Handshake qualification; flush masks every push, pop and drop this cycle.
    // A pop on a full FIFO frees the slot that a same-cycle push then uses.
    assign pop_req = out_valid && out_ready;
    assign pop     = pop_req && !flush;
    assign push    = in_valid && (!full || pop_req) && !flush;
    assign drop    = in_valid && full && !pop_req && !flush;

    // Next-state for pointers, occupancy and statistics.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        inv_d    = inv_q;
        acc_d    = acc_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (drop && (drop_q != SAT_MAX)) begin
                drop_d = drop_q + 16'd1;
            end
            if (push && in_invalid && (inv_q != SAT_MAX)) begin
                inv_d = inv_q + 16'd1;
            end
            if (pop && !out_invalid) begin
                acc_d = acc_q + CNT_W'(out_data);
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            inv_q    <= '0;
            acc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            inv_q    <= inv_d;
            acc_q    <= acc_d;
        end
    end

    // Storage array; contents survive reset since occupancy alone marks validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_invalid, in_opcode, in_out};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alsu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_result_buffer
//  Description : Self-checking bench for alsu_result_buffer using a queue
//                based reference model and directed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alsu_result_buffer;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_out = '0;
    logic [15:0]        in_leds = '0;
    logic [2:0]         in_opcode = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic [2:0]         out_opcode;
    logic               out_invalid;
    logic [3:0]         count;
    logic               full;
    logic               empty;
    logic [15:0]        drop_count;
    logic [15:0]        invalid_count;
    logic [CNT_W-1:0]   acc;

    int n_checks = 0;
    int n_fail   = 0;

    alsu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_out(in_out),
        .in_leds(in_leds), .in_opcode(in_opcode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_opcode(out_opcode), .out_invalid(out_invalid), .count(count),
        .full(full), .empty(empty), .drop_count(drop_count),
        .invalid_count(invalid_count), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              inv;
        logic [2:0]        op;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t      m_q[$];
    int          m_drop = 0;
    int          m_inv  = 0;
    int          m_acc  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_drop = 0;
            m_inv  = 0;
            m_acc  = 0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            bit     do_pop;
            bit     was_full;
            entry_t e;
            do_pop   = (m_q.size() > 0) && out_ready;
            was_full = (m_q.size() == DEPTH);
            if (in_valid && was_full && !do_pop && m_drop < 65535) m_drop++;
            if (do_pop) begin
                e = m_q.pop_front();
                if (!e.inv) m_acc = (m_acc + int'(e.d)) % 65536;
            end
            if (in_valid && (!was_full || do_pop)) begin
                e.inv = (in_leds != 0);
                e.op  = in_opcode;
                e.d   = in_out;
                m_q.push_back(e);
                if (e.inv && m_inv < 65535) m_inv++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("invalid_count", 32'(invalid_count), 32'(m_inv));
        check("acc", 32'(acc), 32'(m_acc));
        if (m_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(m_q[0].d));
            check("out_opcode", 32'(out_opcode), 32'(m_q[0].op));
            check("out_invalid", 32'(out_invalid), 32'(m_q[0].inv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [DATA_W-1:0] d,
                            input logic [2:0] op, input logic [15:0] leds);
        in_valid  = v;
        in_out    = d;
        in_opcode = op;
        in_leds   = leds;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Build acc = 20, then 5 stored entries, then async reset between edges
        drive_in(1, 6'd6, 3'd1, 16'h0); tick();
        drive_in(1, 6'd7, 3'd2, 16'h0); tick();
        drive_in(1, 6'd7, 3'd3, 16'h0); tick();
        drive_in(0, 6'd0, 3'd0, 16'h0);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("acc 20", 32'(acc), 32'd20);
        for (int i = 1; i <= 5; i++) begin
            drive_in(1, DATA_W'(i), 3'(i), 16'h0);
            tick();
        end
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("count 5", 32'(count), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async count", 32'(count), 32'd0);
        check("async acc", 32'(acc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fill 1..8 with opcodes 0..7
        for (int i = 0; i < 8; i++) begin
            drive_in(1, DATA_W'(i + 1), 3'(i), 16'h0);
            tick();
        end
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("fill full", 32'(full), 32'd1);
        check("fill count", 32'(count), 32'd8);

        // Overflow with no consumer
        drive_in(1, 6'h3F, 3'd7, 16'h0);
        repeat (3) tick();
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("ovf drop", 32'(drop_count), 32'd3);
        check("ovf head", 32'(out_data), 32'd1);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain data", 32'(out_data), 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        check("drain acc", 32'(acc), 32'd36);
        check("drain empty", 32'(empty), 32'd1);

        // Refill, then overflow while consuming: no drop
        for (int i = 0; i < 8; i++) begin
            drive_in(1, DATA_W'(i + 1), 3'(i), 16'h0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 9; i <= 11; i++) begin
            drive_in(1, DATA_W'(i), 3'd5, 16'h0);
            tick();
        end
        drive_in(0, 6'd0, 3'd0, 16'h0);
        out_ready = 1'b0;
        check("ovf2 drop", 32'(drop_count), 32'd3);
        check("ovf2 count", 32'(count), 32'd8);
        check("ovf2 head", 32'(out_data), 32'd4);
        check("ovf2 acc", 32'(acc), 32'd42);
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        check("drain2 acc", 32'(acc), 32'd102);

        // Invalid tagging
        drive_in(1, 6'h2A, 3'd3, 16'hFFFF); tick();
        drive_in(1, 6'd5, 3'd4, 16'h0000); tick();
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("inv count", 32'(invalid_count), 32'd1);
        check("inv head flag", 32'(out_invalid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("inv second flag", 32'(out_invalid), 32'd0);
        tick();
        out_ready = 1'b0;
        check("inv acc", 32'(acc), 32'd107);

        // Flush priority over push and pop
        for (int i = 1; i <= 4; i++) begin
            drive_in(1, DATA_W'(i), 3'd1, 16'h0);
            tick();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        drive_in(1, 6'd9, 3'd2, 16'h1);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("flush count", 32'(count), 32'd0);
        check("flush empty", 32'(empty), 32'd1);
        check("flush acc", 32'(acc), 32'd107);
        check("flush drop", 32'(drop_count), 32'd3);
        check("flush inv", 32'(invalid_count), 32'd1);

        // Wrap: 20 push/pop cycles with rotating data
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_in(1, DATA_W'(i + 20), 3'(i), 16'h0);
            tick();
        end
        drive_in(0, 6'd0, 3'd0, 16'h0);
        repeat (2) tick();
        out_ready = 1'b0;
        check("wrap empty", 32'(empty), 32'd1);

        // Saturate drop_count
        for (int i = 0; i < 8; i++) begin
            drive_in(1, DATA_W'(i), 3'(i), 16'h0);
            tick();
        end
        drive_in(1, 6'h11, 3'd1, 16'h0);
        repeat (65540) tick();
        drive_in(0, 6'd0, 3'd0, 16'h0);
        check("drop sat", 32'(drop_count), 32'hFFFF);
        tick();
        check("drop hold", 32'(drop_count), 32'hFFFF);
        check("sat head", 32'(out_data), 32'd0);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alsu_result_buffer.md
# alsu_result_buffer

Downstream stage of the ALSU: captures each qualified ALSU result (`out`, `leds`, and the opcode that produced it) into an 8-deep show-ahead FIFO. It presents the results to a consumer over a valid/ready handshake. It tags results the ALSU flagged as invalid (`leds` non-zero) and keeps saturating statistics plus a running sum of the valid results drained.

## Interface
- `DATA_W`, default 6: ALSU result width.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: width of `acc`.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. ALSU result qualifier.
- `in_out`: input, DATA_W bits. ALSU `out`.
- `in_leds`: input, 16 bits. ALSU `leds`; non-zero marks an invalid result.
- `in_opcode`: input, 3 bits. Opcode that produced `in_out`.
- `flush`: input, 1 bit. Synchronous FIFO clear.
- `out_valid`: output, 1 bit. Head entry available.
- `out_ready`: input, 1 bit. Consumer accepts the head entry.
- `out_data`: output, DATA_W bits. Head result.
- `out_opcode`: output, 3 bits. Head opcode.
- `out_invalid`: output, 1 bit. Head entry was flagged invalid.
- `count`: output, $clog2(DEPTH)+1 bits. Occupancy, 0..DEPTH.
- `full`: output, 1 bit. `count == DEPTH`.
- `empty`: output, 1 bit. `count == 0`.
- `drop_count`: output, 16 bits. Results lost to overflow; saturates at 16'hFFFF.
- `invalid_count`: output, 16 bits. Accepted entries with the invalid flag; saturating.
- `acc`: output, CNT_W bits. Sum of `out_data` over popped valid entries; wraps modulo 2^CNT_W.

## Operation
- Entry = {invalid, opcode, data}, where invalid = (`in_leds != 0`).
- pop = `out_valid && out_ready`.
- push = `in_valid && (!full || pop)`. When full, a simultaneous pop frees a slot in the same cycle.
- drop = `in_valid && full && !pop`. The entry is discarded and `drop_count` increments.
- Occupancy update:
  - push only: `count` +1.
  - pop only: `count` −1.
  - push and pop together: `count` unchanged.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH−1 to 0.
- Show-ahead read: `out_data`, `out_opcode`, and `out_invalid` come combinationally from mem[rd_ptr]. `out_valid = !empty`.
- Outputs are don't-care while `out_valid` is 0. The bench checks them only when `out_valid` is 1.
- On push with invalid = 1, `invalid_count` increments (saturating). Dropped entries never touch `invalid_count`.
- On pop with `out_invalid = 0`, `acc` += zero-extended `out_data`. Popped invalid entries leave `acc` unchanged.
- `flush` is the highest priority:
  - Next edge: `rd_ptr`, `wr_ptr`, and `count` become 0.
  - Any same-cycle push or pop is ignored.
  - A same-cycle `in_valid` is neither stored nor counted as a drop.
  - `drop_count`, `invalid_count`, and `acc` are preserved.
- Reset (`rst` = 0, asynchronous) clears:
  - both pointers and `count` to 0;
  - `drop_count`, `invalid_count`, and `acc` to 0.
  - Memory contents are not cleared.
- Reset values of the outputs:
  - `out_valid` = 0, `empty` = 1, `full` = 0, `count` = 0.
  - `drop_count` = 0, `invalid_count` = 0, `acc` = 0.
- Reset mid-operation discards all stored entries immediately. There is no partial pop.

## Timing
- Write latency is 1 cycle. A push at edge N gives `out_valid` = 1 and valid head data after edge N.
- Push into an empty FIFO: a pop is impossible in that cycle, so only the push takes effect.
- A pop at edge N advances the head after edge N. `acc` and `count` reflect the pop after edge N.
- `full`, `empty`, and `count` are registered-derived. They change only on edges or on reset assertion.
- Reset release: the first edge at which `rst` is sampled high may accept a push.

## Test plan
- Fill and drain:
  - Stimulus: push results 1..8 with opcodes 0..7 and `out_ready` = 0.
  - Required: `full` = 1 and `count` = 8.
  - Then raise `out_ready`. Required: values pop in order 1..8 over 8 cycles and `acc` = 36.
- Overflow:
  - Stimulus: with the FIFO full and `out_ready` = 0, drive 3 more `in_valid` cycles.
  - Required: `drop_count` = 3 and contents unchanged.
  - Repeat with `out_ready` = 1. Required: no drop, head advances, `count` stays 8.
- Invalid tagging:
  - Stimulus: push data 6'h2A with `in_leds` = 16'hFFFF, then data 5 with `in_leds` = 0.
  - Required: `invalid_count` = 1, first pop shows `out_invalid` = 1, and after both pops `acc` = 5.
- Flush priority:
  - Stimulus: with 4 entries stored, assert `flush` together with `in_valid` and `out_ready`.
  - Required: next cycle `count` = 0 and `empty` = 1; `acc`, `drop_count`, and `invalid_count` are unchanged.
- Async reset mid-stream:
  - Stimulus: drive `rst` low between edges while 5 entries are stored and `acc` = 20.
  - Required: immediately `out_valid` = 0, `count` = 0, and `acc` = 0, without waiting for a clock edge.
- Wrap and saturate:
  - Stimulus: run 20 push/pop cycles. Required: pointers wrap and data order is preserved.
  - Stimulus: force 65536 drops. Required: `drop_count` holds at 16'hFFFF.
